nios_system_switch_pio: RTL

Parametrised Avalon-MM input PIO for the Nios system. Brings up to 32 asynchronous switch/button inputs into the `clk` domain through a two-flop synchroniser, optionally debounces them, and latches selected edges into a sticky edge-capture register. A per-bit interrupt mask drives a level IRQ to the processor. Supersedes the fixed 8-bit, read-only switch port.

---
 rtl/nios_system_switch_pio.sv | 128 ++++++++++++
 1 files changed

// File: rtl/nios_system_switch_pio.sv
// Avalon-MM input PIO: synchronised switch inputs, sticky edge capture and a masked level IRQ.
// Optional per-bit debounce is compiled in with `define NIOS_SYSTEM_SWITCH_PIO_DEBOUNCE_EN.
module nios_system_switch_pio #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned EDGE_TYPE       = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [31:0]           readdata,
    output logic                  irq
);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_MASK   = 2'd2;
    localparam logic [1:0] ADDR_EDGE   = 2'd3;
    localparam logic [1:0] WARM_DONE   = 2'd3;

    logic [DATA_WIDTH-1:0] sync1;
    logic [DATA_WIDTH-1:0] sync2;
    logic [DATA_WIDTH-1:0] f_val;
    logic [DATA_WIDTH-1:0] prev;
    logic [DATA_WIDTH-1:0] irqmask;
    logic [DATA_WIDTH-1:0] edgecapture;
    logic [DATA_WIDTH-1:0] edge_raw;
    logic [DATA_WIDTH-1:0] edge_det;
    logic [DATA_WIDTH-1:0] clr_mask;
    logic [DATA_WIDTH-1:0] wdata_trunc;
    logic [1:0]            warm;
    logic                  wr_en;
    logic                  unused_wdata;

    assign wr_en        = chipselect && !write_n;
    assign wdata_trunc  = writedata[DATA_WIDTH-1:0];
    assign unused_wdata = ^writedata;

    // Two-flop synchroniser for the asynchronous switch inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

`ifdef NIOS_SYSTEM_SWITCH_PIO_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] db_cnt [DATA_WIDTH];

    // A bit only follows sync2 after it has differed for DEBOUNCE_CYCLES consecutive cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            f_val <= '0;
            for (int i = 0; i < DATA_WIDTH; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (sync2[i] == f_val[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    f_val[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end
`else
    assign f_val = sync2;
`endif

    always_comb begin
        edge_raw = f_val ^ prev;
        if (EDGE_TYPE == 1) begin
            edge_raw = f_val & ~prev;
        end else if (EDGE_TYPE == 2) begin
            edge_raw = ~f_val & prev;
        end
    end

    // Power-on levels must not look like edges, so detection waits for the warm-up counter
    assign edge_det = (warm == WARM_DONE) ? edge_raw : '0;
    assign clr_mask = (wr_en && address == ADDR_EDGE) ? wdata_trunc : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev        <= '0;
            warm        <= '0;
            irqmask     <= '0;
            edgecapture <= '0;
        end else begin
            prev <= f_val;
            if (warm != WARM_DONE) begin
                warm <= warm + 2'd1;
            end
            if (wr_en && address == ADDR_MASK) begin
                irqmask <= wdata_trunc;
            end
            // A fresh edge overrides a simultaneous clear
            edgecapture <= (edgecapture & ~clr_mask) | edge_det;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            case (address)
                ADDR_DATA: readdata <= 32'(f_val);
                ADDR_MASK: readdata <= 32'(irqmask);
                ADDR_EDGE: readdata <= 32'(edgecapture);
                default:   readdata <= '0;
            endcase
        end
    end

    assign irq = |(edgecapture & irqmask);

endmodule
